// File: rtl/cpu_pkg.sv
// Shared CPU-wide register file constants and types used by the writeback path.
package cpu_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT  = 16;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_COUNT-1:0]  reg_sel_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // Register 0 is hardwired to zero, so it never gets a select line.
  function automatic reg_sel_t addr_to_sel(input reg_addr_t addr);
    reg_sel_t sel;
    sel = '0;
    if (addr != '0) sel[addr] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant_onehot,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  localparam logic [PTR_W:0] LAST = (PTR_W+1)'(N-1);
  localparam logic [PTR_W:0] NUM  = (PTR_W+1)'(N);

  logic [2*N-1:0]   doubled;
  logic [2*N-1:0]   rotated;
  logic [N-1:0]     window;
  logic [PTR_W-1:0] offset;
  logic             found;
  logic [PTR_W:0]   sum;

  // Rotating the doubled vector puts index ptr at bit 0, so a plain
  // priority encode on the low N bits gives the offset from ptr.
  always_comb begin
    doubled = {req, req};
    rotated = doubled >> ptr;
    window  = rotated[N-1:0];
    any     = |req;
    offset  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && window[i]) begin
        found  = 1'b1;
        offset = PTR_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum > LAST) sum = sum - NUM;
    grant_idx    = sum[PTR_W-1:0];
    grant_onehot = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NUM_REQ writeback sources.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [(1<<ADDR_W)-1:0]    wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SEL_W = 1 << ADDR_W;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic               handshake;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req          (req_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    req_ready = '0;
    if (grant_any && !wr_stall && !reset) req_ready = grant_onehot;
    handshake = |(req_valid & req_ready);
    busy      = |req_valid;
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stall freezes everything, including a pending write strobe; a grant to
  // address 0 still consumes the requester but produces no strobe.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    if (!wr_stall) begin
      if (handshake) begin
        wr_en_d   = (win_addr != '0);
        wr_addr_d = win_addr;
        wr_data_d = win_data;
        wr_sel_d  = (win_addr != '0) ? (SEL_W'(1) << win_addr) : '0;
        rr_ptr_d  = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        wr_en_d  = 1'b0;
        wr_sel_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
  a_sel_onehot    : assert property (@(posedge clk) wr_en |-> $onehot(wr_sel));
  a_sel_idle      : assert property (@(posedge clk) !wr_en |-> (wr_sel == '0));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed-vector bench for reg_write_arbiter with hand-computed expectations.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic        busy;

  int vectors;
  int miscompares;

  reg_write_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (32),
    .ADDR_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[i*4 +: 4]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_stall = 1'b0; req_valid = 4'b1111;
    set_req(0, 4'd1, 32'h0000_00A1); set_req(1, 4'd2, 32'h0000_00A2);
    set_req(2, 4'd3, 32'h0000_00A3); set_req(3, 4'd4, 32'h0000_00A4);
    tick(); tick();
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    vectors++; if (wr_sel !== 16'h0000) begin miscompares++; $display("FAIL reset_wr_sel: got %h want 0000", wr_sel); end
    vectors++; if (wr_addr !== 4'd0 || wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_addr_data: got %h/%h want 0/0", wr_addr, wr_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL release_ready: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    #1;
    vectors++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_busy: got busy=%b ready=%b want 0/0000", busy, req_ready); end
  endtask

  task automatic test_single();
    set_req(2, 4'd5, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_sel !== 16'h0020 || wr_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL single_write: got en=%b addr=%0d sel=%h data=%h want 1/5/0020/deadbeef", wr_en, wr_addr, wr_sel, wr_data);
    end
    req_valid = 4'b0000;
    tick();
    vectors++; if (wr_en !== 1'b0 || wr_sel !== 16'h0000 || wr_addr !== 4'd5 || wr_data !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL single_idle_hold: got en=%b addr=%0d sel=%h data=%h want 0/5/0000/deadbeef", wr_en, wr_addr, wr_sel, wr_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  exp_addr  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [15:0] exp_sel   [5] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0002};
    logic [31:0] exp_data  [5] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA1};
    reset = 1'b1; req_valid = 4'b0000;
    tick();
    reset = 1'b0;
    set_req(0, 4'd1, 32'hA1); set_req(1, 4'd2, 32'hA2);
    set_req(2, 4'd3, 32'hA3); set_req(3, 4'd4, 32'hA4);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (req_ready !== exp_ready[k]) begin miscompares++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_ready[k]); end
      tick();
      vectors++; if (wr_en !== 1'b1 || wr_addr !== exp_addr[k] || wr_sel !== exp_sel[k] || wr_data !== exp_data[k]) begin
        miscompares++; $display("FAIL rr_write%0d: got en=%b addr=%0d sel=%h data=%h want 1/%0d/%h/%h", k, wr_en, wr_addr, wr_sel, wr_data, exp_addr[k], exp_sel[k], exp_data[k]);
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_stall();
    set_req(1, 4'd2, 32'h1111_0001);
    set_req(3, 4'd7, 32'h3333_0007);
    req_valid = 4'b1000;
    tick();
    wr_stall = 1'b1;
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL stall_ready%0d: got %b want 0000", k, req_ready); end
      tick();
      vectors++; if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_sel !== 16'h0080 || wr_data !== 32'h3333_0007) begin
        miscompares++; $display("FAIL stall_frozen%0d: got en=%b addr=%0d sel=%h data=%h want 1/7/0080/33330007", k, wr_en, wr_addr, wr_sel, wr_data);
      end
    end
    wr_stall = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL unstall_grant1: got %b want 0010", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_sel !== 16'h0004 || wr_data !== 32'h1111_0001) begin
      miscompares++; $display("FAIL unstall_write1: got en=%b addr=%0d sel=%h data=%h want 1/2/0004/11110001", wr_en, wr_addr, wr_sel, wr_data);
    end
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL unstall_grant3: got %b want 1000", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_sel !== 16'h0080 || wr_data !== 32'h3333_0007) begin
      miscompares++; $display("FAIL unstall_write3: got en=%b addr=%0d sel=%h data=%h want 1/7/0080/33330007", wr_en, wr_addr, wr_sel, wr_data);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_addr_zero();
    set_req(0, 4'd0, 32'h0000_1234);
    req_valid = 4'b0001;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL zero_ready: got %b want 0001", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b0 || wr_sel !== 16'h0000) begin miscompares++; $display("FAIL zero_write: got en=%b sel=%h want 0/0000", wr_en, wr_sel); end
    set_req(0, 4'd3, 32'h0000_0003);
    set_req(1, 4'd6, 32'h0000_0006);
    req_valid = 4'b0011;
    #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL zero_ptr_advance: got %b want 0010", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_addr !== 4'd6 || wr_sel !== 16'h0040) begin
      miscompares++; $display("FAIL zero_next_write: got en=%b addr=%0d sel=%h want 1/6/0040", wr_en, wr_addr, wr_sel);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    set_req(2, 4'd9, 32'h0000_9999);
    req_valid = 4'b0100;
    #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL mid_ready: got %b want 0100", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b1 || wr_sel !== 16'h0200) begin miscompares++; $display("FAIL mid_write: got en=%b sel=%h want 1/0200", wr_en, wr_sel); end
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
    tick();
    vectors++; if (wr_en !== 1'b0 || wr_sel !== 16'h0000) begin miscompares++; $display("FAIL mid_discard: got en=%b sel=%h want 0/0000", wr_en, wr_sel); end
    reset = 1'b0;
    #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    wr_stall = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_addr_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
